// File: rtl/fadd_arbiter.sv
// Round-robin arbiter and sequencer sharing one floatadd unit between two requesters.
// Each operation clears the adder, runs it for WAIT_CYC cycles, then returns the sum to the issuing port.
module fadd_arbiter #(
    parameter int WAIT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req0_sub,
    output logic        resp0_valid,
    output logic [31:0] resp0_z,
    output logic [1:0]  resp0_ovf,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    input  logic        req1_sub,
    output logic        resp1_valid,
    output logic [31:0] resp1_z,
    output logic [1:0]  resp1_ovf,
    output logic        fa_rst,
    output logic [1:0]  fa_enable,
    output logic [31:0] fa_x,
    output logic [31:0] fa_y,
    input  logic [31:0] fa_z,
    input  logic [1:0]  fa_overflow,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, CAP} state_t;

    localparam logic [7:0] LOAD_VAL = 8'(WAIT_CYC - 1);

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_opSub;
    logic        r_lastGrant;
    logic        r_grantId;
    logic        r_faRst;
    logic [1:0]  r_faEnable;
    logic [31:0] r_faX;
    logic [31:0] r_faY;
    logic        r_resp0Valid;
    logic [31:0] r_resp0Z;
    logic [1:0]  r_resp0Ovf;
    logic        r_resp1Valid;
    logic [31:0] r_resp1Z;
    logic [1:0]  r_resp1Ovf;

    logic w_accept;
    logic w_pick1;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    always_comb begin
        w_pick1  = req1_valid && (!req0_valid || !r_lastGrant);
        w_accept = (r_state == IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready  = w_accept && !w_pick1;
    assign req1_ready  = w_accept && w_pick1;
    assign busy        = (r_state != IDLE);
    assign grant_id    = r_grantId;
    assign fa_rst      = r_faRst;
    assign fa_enable   = r_faEnable;
    assign fa_x        = r_faX;
    assign fa_y        = r_faY;
    assign resp0_valid = r_resp0Valid;
    assign resp0_z     = r_resp0Z;
    assign resp0_ovf   = r_resp0Ovf;
    assign resp1_valid = r_resp1Valid;
    assign resp1_z     = r_resp1Z;
    assign resp1_ovf   = r_resp1Ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_count      <= 8'd0;
            r_opSub      <= 1'b0;
            r_lastGrant  <= 1'b1;
            r_grantId    <= 1'b0;
            r_faRst      <= 1'b0;
            r_faEnable   <= 2'b00;
            r_faX        <= 32'd0;
            r_faY        <= 32'd0;
            r_resp0Valid <= 1'b0;
            r_resp0Z     <= 32'd0;
            r_resp0Ovf   <= 2'b00;
            r_resp1Valid <= 1'b0;
            r_resp1Z     <= 32'd0;
            r_resp1Ovf   <= 2'b00;
        end else begin
            r_resp0Valid <= 1'b0;
            r_resp1Valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_faRst    <= 1'b1;
                    r_faEnable <= 2'b00;
                    if (w_accept) begin
                        r_faX       <= w_pick1 ? req1_x : req0_x;
                        r_faY       <= w_pick1 ? req1_y : req0_y;
                        r_opSub     <= w_pick1 ? req1_sub : req0_sub;
                        r_grantId   <= w_pick1;
                        r_lastGrant <= w_pick1;
                        r_faRst     <= 1'b0;
                        r_state     <= CLR;
                    end
                end
                // The adder sits in reset for this cycle so repeated operands still recompute.
                CLR: begin
                    r_count    <= LOAD_VAL;
                    r_faRst    <= 1'b1;
                    r_faEnable <= r_opSub ? 2'b10 : 2'b01;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (r_count == 8'd0) begin
                        r_faEnable <= 2'b00;
                        r_state    <= CAP;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                CAP: begin
                    if (r_grantId) begin
                        r_resp1Z     <= fa_z;
                        r_resp1Ovf   <= fa_overflow;
                        r_resp1Valid <= 1'b1;
                    end else begin
                        r_resp0Z     <= fa_z;
                        r_resp0Ovf   <= fa_overflow;
                        r_resp0Valid <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
